apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 30 +++
 rtl/apb_master.sv | 67 ++++++
 tb/tb_apb_master.sv | 116 +++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// apb_master_if: command/response and APB requester bundle for apb_master
interface apb_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_timeout;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with wait-state timeout
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic         PCLK,
  input logic         PRESETn,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_timeout;
  logic                  w_done;
  // counter stops at TIMEOUT-1, where the abort fires, so it never wraps
  assign w_done = bus.PREADY || (r_cnt == CW'(TIMEOUT - 1));
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   w_next = bus.cmd_valid ? SETUP : IDLE;
      SETUP:  w_next = ACCESS;
      ACCESS: w_next = w_done ? RESP : ACCESS;
      RESP:   w_next = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.cmd_valid) begin
        r_pwrite <= bus.cmd_write;
        r_paddr  <= bus.cmd_addr;
        r_pwdata <= bus.cmd_wdata;
      end
      if (r_state == SETUP)
        r_cnt <= '0;
      else if (r_state == ACCESS && !w_done)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == ACCESS && w_done) begin
        r_rdata   <= (bus.PREADY && !r_pwrite) ? bus.PRDATA : '0;
        r_timeout <= !bus.PREADY;
      end
    end
  end
  assign bus.cmd_ready   = r_state == IDLE;
  assign bus.rsp_valid   = r_state == RESP;
  assign bus.PSEL        = r_state == SETUP || r_state == ACCESS;
  assign bus.PENABLE     = r_state == ACCESS;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_timeout = r_timeout;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed scoreboard bench for apb_master
module tb_apb_master;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  int vectors = 0;
  int errs = 0;
  logic [32:0] sb[$];
  apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus();
  apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus.master)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // entered and left at a negedge with the DUT idle
  task automatic run(input bit wr, input logic [7:0] a, input logic [31:0] wd, input int waits,
                     input logic [31:0] rd, input bit to, input int hold, input bit noise);
    int c;
    int lat;
    logic [32:0] e;
    lat = to ? 18 : 3 + waits;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.rsp_ready = 0;
    bus.PREADY = noise; bus.PRDATA = noise ? 32'hFFFFFFFF : 32'h0;
    sb.push_back({to, (wr || to) ? 32'h0 : rd});
    c = 0;
    @(negedge PCLK); c = 1;
    bus.cmd_valid = 0; bus.cmd_addr = ~a; bus.cmd_wdata = ~wd; bus.cmd_write = ~wr;
    chk("setup_psel", bus.PSEL, 1);
    chk("setup_penable", bus.PENABLE, 0);
    chk("setup_cmd_ready", bus.cmd_ready, 0);
    chk("setup_pwrite", bus.PWRITE, wr);
    chk("setup_paddr", bus.PADDR, a);
    chk("setup_pwdata", bus.PWDATA, wd);
    while (!bus.rsp_valid && c < 40) begin
      @(negedge PCLK); c++;
      if (!bus.rsp_valid) begin
        chk("access_psel", bus.PSEL, 1);
        chk("access_penable", bus.PENABLE, 1);
        chk("access_paddr", bus.PADDR, a);
        chk("access_pwdata", bus.PWDATA, wd);
        bus.PREADY = !to && c >= 2 + waits;
        bus.PRDATA = rd;
      end
    end
    bus.PREADY = 0;
    chk("rsp_latency", c, lat);
    e = sb.size() > 0 ? sb[0] : 33'h0;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1;
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp", {bus.rsp_timeout, bus.rsp_rdata}, e);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      chk("hold_psel", bus.PSEL, 0);
      @(negedge PCLK);
    end
    chk("resp_psel", bus.PSEL, 0);
    chk("resp_penable", bus.PENABLE, 0);
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_data", {bus.rsp_timeout, bus.rsp_rdata}, e);
    end
    bus.rsp_ready = 1;
    @(negedge PCLK);
    bus.rsp_ready = 0; bus.cmd_valid = 0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
  endtask
  initial begin
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.rsp_ready = 0; bus.PREADY = 0; bus.PRDATA = 0;
    #12;
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp", {bus.rsp_timeout, bus.rsp_rdata}, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK); PRESETn = 1;
    run(1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 0, 0, 0);
    run(0, 8'h20, 32'h0, 2, 32'h12345678, 0, 0, 0);
    run(0, 8'h30, 32'h0, 0, 32'hCAFE0000, 1, 0, 0);
    run(0, 8'h40, 32'h0, 1, 32'h55AA55AA, 0, 4, 0);
    run(0, 8'h50, 32'h0, 1, 32'hA5A5A5A5, 0, 0, 1);
    run(1, 8'hFF, 32'h00000001, 3, 32'h77777777, 0, 0, 0);
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 8'h66; bus.cmd_wdata = 32'h600D;
    @(negedge PCLK); bus.cmd_valid = 0;
    @(negedge PCLK); bus.PREADY = 0;
    chk("pre_rst_penable", bus.PENABLE, 1);
    #2 PRESETn = 0;
    #1;
    chk("arst_psel", bus.PSEL, 0);
    chk("arst_penable", bus.PENABLE, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_paddr", bus.PADDR, 0);
    @(negedge PCLK); PRESETn = 1; bus.PREADY = 1; bus.rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("post_rst_rsp_valid", bus.rsp_valid, 0);
      chk("post_rst_psel", bus.PSEL, 0);
    end
    bus.PREADY = 0; bus.rsp_ready = 0;
    run(0, 8'h01, 32'h0, 0, 32'h0BADF00D, 0, 1, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
